// File: rtl/uart_dumper_if.sv
// LPDDR controller read-port bundle (command FIFO + read FIFO) used by uart_dumper.
// master: the port user that issues reads; slave: the memory controller side.
interface uart_dumper_if;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_empty;
  logic        mem_cmd_full;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_full;
  logic        mem_rd_empty;
  logic [6:0]  mem_rd_count;
  logic        mem_rd_overflow;
  logic        mem_rd_error;

  modport master (
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    input  mem_cmd_empty, mem_cmd_full, mem_rd_data, mem_rd_full, mem_rd_empty,
    input  mem_rd_count, mem_rd_overflow, mem_rd_error
  );

  modport slave (
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    output mem_cmd_empty, mem_cmd_full, mem_rd_data, mem_rd_full, mem_rd_empty,
    output mem_rd_count, mem_rd_overflow, mem_rd_error
  );
endinterface

// File: rtl/uart_dumper.sv
// uart_dumper: streams DUMP_BYTES of memory, from byte address 0, out of an
// 8N1 UART as raw bytes, MSB of each 32-bit word first. One 16-word read burst
// is outstanding at a time. The next word is fetched while the last byte of the
// current word is still on the line, so frames run back to back when data is ready.
module uart_dumper #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DUMP_BYTES = 65536
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          calib_done,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    progress,
  output logic          tx,
  uart_dumper_if.master mem
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int TW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(DIVISOR - 1);
  localparam logic [29:0]   LAST_ADDR = 30'(DUMP_BYTES - 64);

  typedef enum logic [2:0] {IDLE, CMD, WAIT, POP, SEND, FIN} state_t;
  typedef enum logic [1:0] {TIDLE, START, DATA, STOP} tx_state_t;

  state_t      state_r;
  tx_state_t   tx_state_r;
  logic [TW-1:0] timer_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic        tx_r;
  logic [31:0] word_r;
  logic [2:0]  idx_r;      // next byte of word_r to hand to the transmitter (4 = all handed over)
  logic [3:0]  wcnt_r;     // word index within the current burst
  logic [29:0] addr_r;
  logic [16:0] cnt_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic        mem_cmd_en_r;
  logic        mem_rd_en_r;

  logic        byte_done_s;
  logic        tx_free_s;
  logic        fault_s;
  logic        load_s;
  logic [7:0]  load_byte_s;
  logic        unused_s;

  assign byte_done_s = (tx_state_r == STOP) && (timer_r == {TW{1'b0}});
  // The transmitter can take a new byte when idle or on the final cycle of a stop bit.
  assign tx_free_s   = (tx_state_r == TIDLE) || byte_done_s;
  assign fault_s     = error_r | mem.mem_rd_error | mem.mem_rd_overflow;
  assign unused_s    = ^{mem.mem_cmd_empty, mem.mem_rd_full, mem.mem_rd_count};

  // Select the byte handed to the transmitter; nothing new is loaded once a fault is seen.
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    if (!fault_s && tx_free_s) begin
      case (state_r)
        POP: begin
          load_s      = 1'b1;
          load_byte_s = mem.mem_rd_data[31:24];
        end
        SEND: begin
          if (idx_r != 3'd4) begin
            load_s = 1'b1;
            case (idx_r)
              3'd0:    load_byte_s = word_r[31:24];
              3'd1:    load_byte_s = word_r[23:16];
              3'd2:    load_byte_s = word_r[15:8];
              default: load_byte_s = word_r[7:0];
            endcase
          end else begin
            load_s = 1'b0;
          end
        end
        default: load_s = 1'b0;
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Main sequencer: burst commands, word pops, byte hand-off, dump termination and faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      word_r       <= 32'h0000_0000;
      idx_r        <= 3'd0;
      wcnt_r       <= 4'd0;
      addr_r       <= 30'd0;
      cnt_r        <= 17'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      mem_cmd_en_r <= 1'b0;
      mem_rd_en_r  <= 1'b0;
    end else begin
      mem_cmd_en_r <= 1'b0;
      mem_rd_en_r  <= 1'b0;
      if (byte_done_s) cnt_r <= cnt_r + 17'd1;
      if ((state_r != IDLE) && (mem.mem_rd_error || mem.mem_rd_overflow)) error_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start && calib_done) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            cnt_r   <= 17'd0;
            addr_r  <= 30'd0;
            wcnt_r  <= 4'd0;
            idx_r   <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= CMD;
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          if (fault_s) begin
            // Let the byte in flight finish; leave the read FIFO as it is.
            if (tx_free_s) state_r <= FIN;
          end else begin
            case (state_r)
              CMD: begin
                if (!mem.mem_cmd_full) begin
                  mem_cmd_en_r <= 1'b1;
                  state_r      <= WAIT;
                end
              end
              WAIT: begin
                if (!mem.mem_rd_empty) begin
                  mem_rd_en_r <= 1'b1;
                  state_r     <= POP;
                end
              end
              POP: begin
                word_r  <= mem.mem_rd_data;
                idx_r   <= load_s ? 3'd1 : 3'd0;
                state_r <= SEND;
              end
              SEND: begin
                if (idx_r == 3'd4) begin
                  if (wcnt_r != 4'd15) begin
                    wcnt_r  <= wcnt_r + 4'd1;
                    idx_r   <= 3'd0;
                    state_r <= WAIT;
                  end else if (addr_r != LAST_ADDR) begin
                    wcnt_r  <= 4'd0;
                    idx_r   <= 3'd0;
                    addr_r  <= addr_r + 30'd64;
                    state_r <= CMD;
                  end else if (byte_done_s) begin
                    addr_r  <= addr_r + 30'd64;
                    state_r <= FIN;
                  end
                end else if (load_s) begin
                  idx_r <= idx_r + 3'd1;
                end
              end
              default: state_r <= FIN;
            endcase
          end
        end
      endcase
    end
  end

  // 8N1 transmitter; a byte offered on the last stop cycle starts with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TIDLE;
      timer_r    <= {TW{1'b0}};
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      tx_r       <= 1'b1;
    end else begin
      case (tx_state_r)
        TIDLE: begin
          tx_r <= 1'b1;
          if (load_s) begin
            tx_state_r <= START;
            tx_r       <= 1'b0;
            shift_r    <= load_byte_s;
            timer_r    <= BIT_LAST;
          end
        end
        START: begin
          if (timer_r == {TW{1'b0}}) begin
            tx_state_r <= DATA;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
            bit_idx_r  <= 3'd0;
            timer_r    <= BIT_LAST;
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        DATA: begin
          if (timer_r == {TW{1'b0}}) begin
            timer_r <= BIT_LAST;
            if (bit_idx_r == 3'd7) begin
              tx_state_r <= STOP;
              tx_r       <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        STOP: begin
          if (timer_r == {TW{1'b0}}) begin
            if (load_s) begin
              tx_state_r <= START;
              tx_r       <= 1'b0;
              shift_r    <= load_byte_s;
              timer_r    <= BIT_LAST;
            end else begin
              tx_state_r <= TIDLE;
              tx_r       <= 1'b1;
            end
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        default: begin
          tx_state_r <= TIDLE;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  assign tx                    = tx_r;
  assign busy                  = busy_r;
  assign done                  = done_r;
  assign error                 = error_r;
  assign progress              = cnt_r[15:8];
  assign mem.mem_cmd_en        = mem_cmd_en_r;
  assign mem.mem_cmd_instr     = 3'b001;
  assign mem.mem_cmd_bl        = 6'd15;
  assign mem.mem_cmd_byte_addr = addr_r;
  assign mem.mem_rd_en         = mem_rd_en_r;

endmodule

// File: tb/tb_uart_dumper.sv
// Bench for uart_dumper: memory model with 20-cycle read latency, UART frame
// decoder feeding a byte scoreboard, table of dump scenarios plus hand sequences.
module tb_uart_dumper;
  localparam int DIV    = 10;
  localparam int NBYTES = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       calib_done;
  logic       start;
  logic       busy, done, error, tx;
  logic [7:0] progress;

  always #5 clk = ~clk;

  uart_dumper_if mem_if ();

  uart_dumper #(.CLK_FREQ(1000000), .BAUD(100000), .DUMP_BYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .start(start),
    .busy(busy), .done(done), .error(error), .progress(progress), .tx(tx),
    .mem(mem_if.master)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] img(input logic [31:0] seed, input int idx);
    return seed ^ (32'(idx) * 32'h9E37_79B9);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] seed, input int k);
    logic [31:0] w;
    w = img(seed, k / 4);
    case (k % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] seed_cur = 32'h0;
  logic [31:0] rdq[$];
  int          due_q[$];
  logic [29:0] due_addr_q[$];
  int          cyc       = 0;
  int          cmd_count = 0;
  int          cmd_base  = 0;

  always @(posedge clk) begin
    cyc++;
    if (mem_if.mem_cmd_en === 1'b1) begin
      check("cmd_addr", 32'(mem_if.mem_cmd_byte_addr), 32'((cmd_count - cmd_base) * 64));
      check("cmd_instr", 32'(mem_if.mem_cmd_instr), 32'd1);
      check("cmd_bl", 32'(mem_if.mem_cmd_bl), 32'd15);
      cmd_count++;
      due_q.push_back(cyc + 20);
      due_addr_q.push_back(mem_if.mem_cmd_byte_addr);
    end
    if (mem_if.mem_rd_en === 1'b1) begin
      check("rd_en_nonempty", 32'(rdq.size() != 0), 32'd1);
      if (rdq.size() != 0) void'(rdq.pop_front());
    end
    if (due_q.size() > 0 && cyc >= due_q[0]) begin
      for (int w = 0; w < 16; w++) rdq.push_back(img(seed_cur, int'(due_addr_q[0] >> 2) + w));
      void'(due_q.pop_front());
      void'(due_addr_q.pop_front());
    end
  end

  always @(negedge clk) begin
    mem_if.mem_rd_data  = (rdq.size() > 0) ? rdq[0] : 32'h0;
    mem_if.mem_rd_empty = (rdq.size() == 0);
    mem_if.mem_rd_count = 7'(rdq.size());
    mem_if.mem_rd_full  = (rdq.size() >= 64);
  end

  // ---------------- UART monitor / scoreboard ----------------
  logic [7:0] sb_q[$];
  int         frames_total = 0;
  int         dump_id      = 0;
  bit         mon_en       = 1'b1;

  initial begin : monitor
    int         last_start;
    int         last_id;
    logic [7:0] rx;
    last_start = 0;
    last_id    = -1;
    rx         = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        frames_total++;
        if (mon_en && last_id == dump_id) check("frame_spacing", 32'(cyc - last_start), 32'(DIV * 10));
        last_start = cyc;
        last_id    = dump_id;
        repeat (DIV / 2) @(negedge clk);
        if (mon_en) check("start_bit", 32'(tx), 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          rx[b] = tx;
        end
        repeat (DIV) @(negedge clk);
        if (mon_en) begin
          check("stop_bit", 32'(tx), 32'd1);
          check("byte_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) check("byte_value", 32'(rx), 32'(sb_q.pop_front()));
        end
        repeat (DIV / 2 - 1) @(negedge clk);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] seed;
    int          full_hold;
    int          err_byte;
    bit          start_again;
    int          exp_bytes;
    logic        exp_error;
    int          exp_cmds;
    int          exp_left;
  } vec_t;

  vec_t vecs[4];

  initial begin : driver
    int fbase;
    int cbase;
    int n;
    vecs[0] = '{32'hA55A_0F01, 0,  -1, 1'b1, NBYTES, 1'b0, 2, 0};
    vecs[1] = '{32'h1234_5678, 50, -1, 1'b0, NBYTES, 1'b0, 2, 0};
    vecs[2] = '{32'hC3C3_0F0F, 0,   5, 1'b0, 6,      1'b1, 1, 14};
    vecs[3] = '{32'hDEAD_BEEF, 0,  -1, 1'b0, NBYTES, 1'b0, 2, 0};

    rst_n = 1'b0;
    calib_done = 1'b1;
    start = 1'b0;
    mem_if.mem_cmd_full = 1'b0;
    mem_if.mem_cmd_empty = 1'b1;
    mem_if.mem_rd_error = 1'b0;
    mem_if.mem_rd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_progress", 32'(progress), 32'd0);
    check("rst_cmd_en", 32'(mem_if.mem_cmd_en), 32'd0);
    check("rst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_if.mem_cmd_byte_addr), 32'd0);
    rst_n = 1'b1;
    cbase = cmd_count;
    repeat (1000) @(negedge clk);
    check("idle_no_cmd", 32'(cmd_count - cbase), 32'd0);

    for (int v = 0; v < 4; v++) begin
      rdq.delete();
      due_q.delete();
      due_addr_q.delete();
      seed_cur = vecs[v].seed;
      dump_id++;
      fbase = frames_total;
      cbase = cmd_count;
      cmd_base = cmd_count;
      for (int k = 0; k < vecs[v].exp_bytes; k++) sb_q.push_back(exp_byte(vecs[v].seed, k));
      mem_if.mem_cmd_full = (vecs[v].full_hold > 0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_done_clr", 32'(done), 32'd0);
      check("start_error_clr", 32'(error), 32'd0);
      if (vecs[v].full_hold > 0) begin
        repeat (vecs[v].full_hold) @(negedge clk);
        check("cmd_held_while_full", 32'(cmd_count - cbase), 32'd0);
        mem_if.mem_cmd_full = 1'b0;
      end
      if (vecs[v].err_byte >= 0) begin
        n = 0;
        while (frames_total - fbase < vecs[v].err_byte + 1 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        check("err_byte_reached", 32'(n < 20000), 32'd1);
        repeat (30) @(negedge clk);
        mem_if.mem_rd_error = 1'b1;
        @(negedge clk);
        mem_if.mem_rd_error = 1'b0;
      end
      if (vecs[v].start_again) begin
        repeat (300) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      n = 0;
      while (done !== 1'b1 && n < 20000) begin
        @(negedge clk);
        n++;
      end
      repeat (3) @(negedge clk);
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_error", 32'(error), 32'(vecs[v].exp_error));
      check("end_progress", 32'(progress), 32'd0);
      check("end_cmds", 32'(cmd_count - cbase), 32'(vecs[v].exp_cmds));
      check("end_frames", 32'(frames_total - fbase), 32'(vecs[v].exp_bytes));
      check("end_sb_empty", 32'(sb_q.size()), 32'd0);
      check("end_fifo_left", 32'(rdq.size()), 32'(vecs[v].exp_left));
      sb_q.delete();
    end

    // start with calibration incomplete is ignored
    calib_done = 1'b0;
    cbase = cmd_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("nocal_busy", 32'(busy), 32'd0);
    check("nocal_done_kept", 32'(done), 32'd1);
    check("nocal_no_cmd", 32'(cmd_count - cbase), 32'd0);
    calib_done = 1'b1;

    // asynchronous reset in the middle of a start bit
    mon_en = 1'b0;
    rdq.delete();
    due_q.delete();
    due_addr_q.delete();
    seed_cur = 32'h0BAD_F00D;
    dump_id++;
    fbase = frames_total;
    cmd_base = cmd_count;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (frames_total - fbase < 2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_progress", 32'(progress), 32'd0);
    check("arst_cmd_en", 32'(mem_if.mem_cmd_en), 32'd0);
    check("arst_rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    check("arst_addr", 32'(mem_if.mem_cmd_byte_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
